// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency word-write / wrapping line-read memory responder (option: MEM_RESPONDER_BYTE_WRITE_EN)
module mem_responder #(
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 3,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
    input  logic [3:0]  req_wstrb,
`endif
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_last
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam logic [3:0]       LAT_LOAD  = 4'(LATENCY - 1);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST,
        ST_WACK
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [OFF_W-1:0]   beat_q, beat_d;
    logic               we_q, we_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
    logic [3:0]         wstrb_q, wstrb_d;
`endif

    logic [31:0]        mem [DEPTH];
    logic               mem_we;
    logic [OFF_W-1:0]   next_beat;
    logic [OFF_W-1:0]   rd_off;
    logic [31:0]        fetch_word;
    logic               unused_addr_bits;

    // Byte-offset bits and address bits above the storage size do not select a word
    assign unused_addr_bits = ^{req_addr[31:IDX_W+2], req_addr[1:0]};

    // In WAIT next_beat is 0 so the fetch targets the critical word; in BURST it targets the following beat
    assign next_beat  = (state_q == ST_BURST) ? beat_q + OFF_W'(1) : '0;
    assign rd_off     = idx_q[OFF_W-1:0] + next_beat;
    assign fetch_word = mem[{idx_q[IDX_W-1:OFF_W], rd_off}];

    assign req_ready  = rst && (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_BURST) || (state_q == ST_WACK);
    assign resp_last  = ((state_q == ST_BURST) && (beat_q == LAST_BEAT)) || (state_q == ST_WACK);
    assign resp_rdata = rdata_q;

    // Next-state and datapath decisions; memory write strobe fires on the final WAIT cycle of a write
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
        wstrb_d = wstrb_q;
`endif
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    state_d = ST_WAIT;
                    cnt_d   = LAT_LOAD;
                    we_d    = req_we;
                    idx_d   = req_addr[IDX_W+1:2];
                    wdata_d = req_wdata;
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
                    wstrb_d = req_wstrb;
`endif
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (we_q) begin
                        mem_we  = 1'b1;
                        state_d = ST_WACK;
                        rdata_d = '0;
                    end else begin
                        state_d = ST_BURST;
                        beat_d  = '0;
                        rdata_d = fetch_word;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_BURST: begin
                if (resp_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d  = next_beat;
                        rdata_d = fetch_word;
                    end
                end
            end
            ST_WACK: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and control registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            rdata_q <= rdata_d;
        end
    end

    // Captured request fields only matter once a request is accepted, so they carry no reset
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
        wstrb_q <= wstrb_d;
`endif
    end

    // Storage survives reset; a write still pending when reset arrives never commits
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
`else
            mem[idx_q] <= wdata_q;
`endif
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder against a word-array reference model
module tb_mem_responder;

    localparam int DEPTH   = 1024;
    localparam int LATENCY = 3;
    localparam int LW      = 4;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          first_cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
    logic [3:0]  req_wstrb = 4'hF;
`endif
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_last;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          rand_ready = 1'b0;

    logic [31:0] ref_mem [DEPTH];
    beat_t       sb [$];

    bit          time_done = 1'b0;
    bit          hold      = 1'b0;
    logic [31:0] hold_data;
    logic        hold_last;

    mem_responder #(
        .DEPTH      (DEPTH),
        .LATENCY    (LATENCY),
        .LINE_WORDS (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
        .req_wstrb  (req_wstrb),
`endif
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_last  (resp_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (rand_ready) resp_ready = ($urandom_range(0, 9) < 7);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every handshaked beat with the head of the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            hold      = 1'b0;
            time_done = 1'b0;
        end else if (resp_valid) begin
            check("req_ready_while_busy", {31'd0, req_ready}, 32'd0);
            if (hold) begin
                check("stall_data_stable", resp_rdata, hold_data);
                check("stall_last_stable", {31'd0, resp_last}, {31'd0, hold_last});
            end
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got data %h, no beat expected", resp_rdata);
            end else begin
                if (sb[0].first_cyc >= 0 && !time_done) begin
                    check("first_beat_cycle", 32'(cyc), 32'(sb[0].first_cyc));
                    time_done = 1'b1;
                end
                if (resp_ready) begin
                    check("beat_data", resp_rdata, sb[0].data);
                    check("beat_last", {31'd0, resp_last}, {31'd0, sb[0].last});
                    void'(sb.pop_front());
                    time_done = 1'b0;
                end
            end
            hold      = !resp_ready;
            hold_data = resp_rdata;
            hold_last = resp_last;
        end else begin
            hold = 1'b0;
        end
    end

    task automatic set_ready(input bit random_mode, input logic val);
        @(posedge clk);
        #1;
        rand_ready = random_mode;
        resp_ready = val;
    endtask

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input bit abort);
        bit          ok;
        logic [31:0] word;
        int          idx;
        int          base;
        int          start;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
        req_wstrb = strb;
`endif
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept_timeout: request at %h not accepted, required within 300 cycles", addr);
        end
        word  = addr >> 2;
        idx   = int'(word % DEPTH);
        base  = idx - (idx % LW);
        start = idx % LW;
        if (ok && !abort) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                sb.push_back('{data: 32'h0, last: 1'b1, first_cyc: cyc + 1 + LATENCY});
            end else begin
                for (int k = 0; k < LW; k++)
                    sb.push_back('{data: ref_mem[base + ((start + k) % LW)], last: (k == LW - 1),
                                   first_cyc: (k == 0) ? cyc + 1 + LATENCY : -1});
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_sb_size(input int n);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            if (sb.size() == n) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL beat_poll_timeout: %0d beats outstanding, required %0d", sb.size(), n);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] addr;
        logic [3:0]  strb;
        bit          we;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", {31'd0, req_ready}, 32'd0);
        check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset_resp_last", {31'd0, resp_last}, 32'd0);
        check("reset_resp_rdata", resp_rdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'd0, req_ready}, 32'd1);

        // Preload words 0..63 so every read below targets known contents
        set_ready(1'b1, 1'b0);
        for (int i = 0; i < 64; i++) do_req(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0);
        wait_idle();

        // Write then read back with the initiator always ready
        set_ready(1'b0, 1'b1);
        do_req(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 1'b0);
        do_req(1'b0, 32'h40, 32'h0, 4'hF, 1'b0);
        wait_idle();

        // Critical-word-first wrap inside a line
        do_req(1'b1, 32'h40, 32'hAAAA0001, 4'hF, 1'b0);
        do_req(1'b1, 32'h44, 32'hBBBB0002, 4'hF, 1'b0);
        do_req(1'b1, 32'h48, 32'hCCCC0003, 4'hF, 1'b0);
        do_req(1'b1, 32'h4C, 32'hDDDD0004, 4'hF, 1'b0);
        do_req(1'b0, 32'h48, 32'h0, 4'hF, 1'b0);
        wait_idle();

        // Back-pressure for 5 cycles on beat 2
        do_req(1'b0, 32'h88, 32'h0, 4'hF, 1'b0);
        wait_sb_size(LW - 1);
        #1 resp_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 resp_ready = 1'b1;
        wait_idle();

        // Reset during a burst after beat 1
        do_req(1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
        wait_sb_size(LW - 1);
        #1;
        resp_ready = 1'b0;
        rst        = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("valid_after_burst_reset", {31'd0, resp_valid}, 32'd0);
        check("last_after_burst_reset", {31'd0, resp_last}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("ready_after_burst_reset", {31'd0, req_ready}, 32'd1);

        // Write aborted while waiting leaves the old value
        set_ready(1'b0, 1'b1);
        do_req(1'b1, 32'h24, ~ref_mem[9], 4'hF, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        do_req(1'b0, 32'h24, 32'h0, 4'hF, 1'b0);
        wait_idle();

        // Word index aliases modulo DEPTH
        do_req(1'b1, 32'h0, 32'h12345678, 4'hF, 1'b0);
        do_req(1'b1, 32'(4 * DEPTH), 32'h55, 4'hF, 1'b0);
        do_req(1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
        wait_idle();

`ifdef MEM_RESPONDER_BYTE_WRITE_EN
        // Byte strobes merge into the existing word
        do_req(1'b1, 32'h30, 32'h11223344, 4'hF, 1'b0);
        do_req(1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, 1'b0);
        do_req(1'b0, 32'h30, 32'h0, 4'hF, 1'b0);
        wait_idle();
`endif

        // Randomized mix with random back-pressure and aliased addresses
        set_ready(1'b1, 1'b0);
        for (int n = 0; n < 60; n++) begin
            we   = 1'($urandom_range(0, 1));
            addr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            strb = 4'hF;
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
            strb = 4'($urandom_range(0, 15));
`endif
            do_req(we, addr, $urandom, strb, 1'b0);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
